mtx_arb_wrr: RTL and testbench
==============================

# mtx_arb_wrr

Weighted, burst-holding matrix arbiter for N requesters. It is the successor to the single-cycle matrix arbiter. Priority is still kept as a least-recently-granted matrix. Each grant is now a registered tenure that lasts up to a programmable number of accepted beats, so the arbiter can sit in front of shared buses and memories that need multi-beat ownership with per-port bandwidth weighting.

## Interface
- N, default 4: number of requesters, at least 2.
- WW, default 4: weight/credit width. The maximum burst per tenure is 2^WW-1 beats.
- IW, derived, $clog2(N): width of gnt_id.
- clk, input, 1: clock. All state changes on the rising edge.
- rstn, input, 1: reset, asynchronous, active-low.
- req, input, N: request per requester. A requester holds it high until it is granted or it gives up.
- wgt, input, N*WW: per-requester weight. Slice i is wgt[i*WW +: WW]. It is sampled only at tenure start. A value of 0 is treated as 1.
- ack, input, 1: the current owner's beat was accepted this cycle. It is ignored when gnt_vld=0.
- last, input, 1: qualified by ack. The owner ends its burst early on this beat.
- gnt, output, N: registered one-hot grant. It is all-zero when idle.
- gnt_vld, output, 1: registered, equal to |gnt.
- gnt_id, output, IW: registered binary index of the owner. It holds its last value when idle.

## Operation
**Priority matrix**
- Element w[i][j]=1 means i has priority over j, for i≠j.
- Reset value: w[i][j]=1 for i<j, so requester 0 is highest.
- The combinational winner among a candidate vector c is the i with c[i]=1 and no j with c[j]=1 and w[j][i]=1. The winner is exactly one-hot whenever c≠0.

**States**
- IDLE, when gnt_vld=0.
- OWN, when gnt_vld=1, the tenure is active and a credit counter cnt (WW bits) is running.

**IDLE**
- If req≠0, the winner of c=req is registered into gnt/gnt_id.
- cnt loads max(wgt[winner],1).
- The next state is OWN.

**OWN, tenure end**
- The tenure ends on either of:
  - ack && (cnt==1 || last), the normal end;
  - !req[owner] && !ack, an abort.
- Otherwise, an ack decrements cnt.

**At tenure end**
- Row owner of the matrix is cleared and column owner is set, so the owner becomes lowest priority.
- The candidate set is c = req & ~onehot(owner).
  - If c≠0, the winner of c is granted next cycle, with no bubble, and cnt reloads from its weight.
  - Else, if req[owner] is still high (normal end only), the owner is re-granted with a fresh cnt.
  - Else, the next state is IDLE.

**Other rules**
- The matrix updates only at tenure end. The relative order of non-owners is unchanged.
- req changes of non-owners during OWN have no effect until tenure end.
- wgt changes during OWN have no effect on the current cnt.
- ack while IDLE is ignored, and last without ack is ignored.

## Timing
- Reset, asynchronous: gnt=0, gnt_vld=0, gnt_id=0, cnt=0, matrix at its reset value, state IDLE. Reset mid-tenure drops the grant immediately and restores priority 0 first.
- Grant latency: req rising in IDLE at edge k gives gnt at edge k+1, so there is 1 cycle from req to gnt.
- Handover:
  - The end-of-tenure ack at edge k moves gnt to the next owner at edge k+1.
  - The abort detected in cycle k moves gnt at edge k+1.
  - There are no idle cycles between owners when c≠0.
- A tenure with weight W and no last/abort lasts exactly W acked beats. Cycles without ack do not consume credit.
- gnt is glitch-free because it is driven from flops only.

## Test plan
1. **Reset priority.** Set N=4, weights all 1, and assert req=4'b1111 from reset. Grants go 0,1,2,3,0,…, one per ack, with no bubble.
2. **Weighting.** Set wgt={1,1,1,3} (requester 0 weight 3), req=4'b0011, ack held high. gnt_id sequence is 0,0,0,1,0,0,0,1.
3. **Early last.** Requester 2 has weight 5 and is alone. Issue ack, ack, ack+last. The tenure ends after 3 beats. Requester 2 is re-granted with cnt=5 next cycle, and gnt stays high throughout.
4. **Abort.** Requester 1 owns the grant. Drop req[1] for one cycle with ack=0 while req[3]=1. On the next edge gnt=4'b1000. Requester 1 is now lowest priority, verified by a following req=4'b0011, which grants 0.
5. **Weight 0 and stall.** wgt[0]=0 with req[0] only. The tenure is exactly 1 acked beat. Holding ack low for 5 cycles keeps gnt=4'b0001 unchanged.
6. **Reset mid-tenure.** Deassert rstn asynchronously during a weight-4 tenure of requester 3 after 2 beats. gnt=0 immediately. After release with req=4'b1001, the grant goes to 0.

Source files
------------

// File: rtl/mtx_arb_wrr.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mtx_arb_wrr
// Weighted, burst-holding matrix arbiter for N requesters. Priority is a
// least-recently-granted matrix. Each grant is a registered tenure that lasts
// up to max(weight,1) accepted beats. It ends early on ack&last, or it is
// aborted when the owner drops req while no beat is being accepted.
//
// Ports
//   clk     : clock, rising edge
//   rstn    : asynchronous active-low reset
//   req     : [N]     request per requester
//   wgt     : [N*WW]  per-requester weight, slice i = wgt[i*WW +: WW]
//   ack     : owner's beat accepted this cycle
//   last    : with ack, owner ends its burst on this beat
//   gnt     : [N]     registered one-hot grant
//   gnt_vld : registered |gnt
//   gnt_id  : [IW]    registered owner index, holds while idle
// ---------------------------------------------------------------------------
module mtx_arb_wrr #(
   parameter  int N  = 4,
   parameter  int WW = 4,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N-1:0]    req,
   input  logic [N*WW-1:0] wgt,
   input  logic            ack,
   input  logic            last,
   output logic [N-1:0]    gnt,
   output logic            gnt_vld,
   output logic [IW-1:0]   gnt_id
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   localparam logic [WW-1:0] CNT_ONE = {{(WW-1){1'b0}}, 1'b1};

   state_t                  state_r, state_s;
   logic [N-1:0]            gnt_r, gnt_s;
   logic [IW-1:0]           id_r, id_s;
   logic [WW-1:0]           cnt_r, cnt_s;
   logic                    vld_r;
   logic [N-1:0][N-1:0]     mtx_r, mtx_s;   // mtx[i][j]=1: i beats j

   logic [N-1:0]            pick_req_s;
   logic [N-1:0]            cand_s;
   logic [N-1:0]            pick_cand_s;
   logic                    owner_req_s;
   logic                    norm_end_s;
   logic                    abort_s;

   // Winner of candidate vector c: the set bit that no other set bit beats.
   function automatic logic [N-1:0] arb_pick(input logic [N-1:0] c,
                                             input logic [N-1:0][N-1:0] m);
      logic [N-1:0] pick;
      logic         beaten;
      pick = '0;
      for (int i = 0; i < N; i++) begin
         beaten = 1'b0;
         for (int j = 0; j < N; j++) begin
            if ((j != i) && c[j] && m[j][i]) begin
               beaten = 1'b1;
            end else begin
               beaten = beaten;
            end
         end
         pick[i] = c[i] & ~beaten;
      end
      return pick;
   endfunction

   // One-hot to binary index.
   function automatic logic [IW-1:0] oh2bin(input logic [N-1:0] oh);
      logic [IW-1:0] b;
      b = '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) begin
            b = b | IW'(i);
         end else begin
            b = b;
         end
      end
      return b;
   endfunction

   // Credit loaded at tenure start; a zero weight still grants one beat.
   function automatic logic [WW-1:0] credit(input logic [N*WW-1:0] w,
                                            input logic [IW-1:0]   idx);
      logic [WW-1:0] v;
      v = w[idx*WW +: WW];
      if (v == '0) begin
         v = CNT_ONE;
      end else begin
         v = v;
      end
      return v;
   endfunction

   // Reset priority: lower index beats higher index.
   function automatic logic [N-1:0][N-1:0] mtx_init();
      logic [N-1:0][N-1:0] m;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            m[i][j] = (i < j);
         end
      end
      return m;
   endfunction

   // Arbitration inputs and tenure-end conditions.
   always_comb begin
      pick_req_s  = arb_pick(req, mtx_r);
      cand_s      = req & ~gnt_r;
      pick_cand_s = arb_pick(cand_s, mtx_r);
      owner_req_s = |(req & gnt_r);
      norm_end_s  = ack & ((cnt_r == CNT_ONE) | last);
      abort_s     = ~owner_req_s & ~ack;
   end

   // Next-state, grant, credit and priority-matrix update.
   always_comb begin
      state_s = state_r;
      gnt_s   = gnt_r;
      id_s    = id_r;
      cnt_s   = cnt_r;
      mtx_s   = mtx_r;
      case (state_r)
         ST_IDLE: begin
            if (|req) begin
               gnt_s   = pick_req_s;
               id_s    = oh2bin(pick_req_s);
               cnt_s   = credit(wgt, oh2bin(pick_req_s));
               state_s = ST_OWN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (norm_end_s | abort_s) begin
               // Owner drops to lowest priority; others keep their order.
               for (int i = 0; i < N; i++) begin
                  for (int j = 0; j < N; j++) begin
                     if (IW'(i) == id_r) begin
                        mtx_s[i][j] = 1'b0;
                     end else if (IW'(j) == id_r) begin
                        mtx_s[i][j] = 1'b1;
                     end else begin
                        mtx_s[i][j] = mtx_r[i][j];
                     end
                  end
               end
               if (|cand_s) begin
                  gnt_s   = pick_cand_s;
                  id_s    = oh2bin(pick_cand_s);
                  cnt_s   = credit(wgt, oh2bin(pick_cand_s));
                  state_s = ST_OWN;
               end else if (norm_end_s & owner_req_s) begin
                  cnt_s   = credit(wgt, id_r);
                  state_s = ST_OWN;
               end else begin
                  gnt_s   = '0;
                  cnt_s   = '0;
                  state_s = ST_IDLE;
               end
            end else if (ack) begin
               cnt_s = cnt_r - CNT_ONE;
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            gnt_s   = '0;
            cnt_s   = '0;
         end
      endcase
   end

   // State, grant and priority registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
         gnt_r   <= '0;
         id_r    <= '0;
         cnt_r   <= '0;
         vld_r   <= 1'b0;
         mtx_r   <= mtx_init();
      end else begin
         state_r <= state_s;
         gnt_r   <= gnt_s;
         id_r    <= id_s;
         cnt_r   <= cnt_s;
         vld_r   <= |gnt_s;
         mtx_r   <= mtx_s;
      end
   end

   assign gnt     = gnt_r;
   assign gnt_vld = vld_r;
   assign gnt_id  = id_r;

endmodule

// File: tb/tb_mtx_arb_wrr.sv
`timescale 1ns/1ps
// Testbench for mtx_arb_wrr: directed scenarios plus randomized traffic
// checked against a priority-list reference model.
module tb_mtx_arb_wrr;

   localparam int N  = 4;
   localparam int WW = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rstn;
   logic [N-1:0]    req;
   logic [N*WW-1:0] wgt;
   logic            ack;
   logic            last;
   logic [N-1:0]    gnt;
   logic            gnt_vld;
   logic [IW-1:0]   gnt_id;

   int errors = 0;
   int checks = 0;

   // Reference model: priority list (front = highest), owner (-1 = idle).
   int m_order[$];
   int m_owner;
   int m_cnt;
   int m_id;

   always #5 clk = ~clk;

   mtx_arb_wrr #(.N(N), .WW(WW)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req),
      .wgt     (wgt),
      .ack     (ack),
      .last    (last),
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req  = '0;
      ack  = 1'b0;
      last = 1'b0;
      wgt  = {N{4'd1}};
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      m_order.delete();
      for (int i = 0; i < N; i++) m_order.push_back(i);
      m_owner = -1;
      m_cnt   = 0;
      m_id    = 0;
   endtask

   function automatic int pick_next(int excl);
      foreach (m_order[k]) begin
         if (m_order[k] != excl && req[m_order[k]]) return m_order[k];
      end
      return -1;
   endfunction

   function automatic int credit_of(int i);
      int v;
      v = int'(wgt[i*WW +: WW]);
      return (v == 0) ? 1 : v;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int nxt;
      bit nend;
      bit ab;
      if (m_owner < 0) begin
         if (req != '0) begin
            m_owner = pick_next(-1);
            m_cnt   = credit_of(m_owner);
         end
      end else begin
         nend = ack && ((m_cnt == 1) || last);
         ab   = !req[m_owner] && !ack;
         if (nend || ab) begin
            for (int k = 0; k < m_order.size(); k++) begin
               if (m_order[k] == m_owner) begin
                  m_order.delete(k);
                  break;
               end
            end
            m_order.push_back(m_owner);
            nxt = pick_next(m_owner);
            if (nxt >= 0) begin
               m_owner = nxt;
               m_cnt   = credit_of(nxt);
            end else if (nend && req[m_owner]) begin
               m_cnt = credit_of(m_owner);
            end else begin
               m_owner = -1;
            end
         end else if (ack) begin
            m_cnt--;
         end
      end
      if (m_owner >= 0) m_id = m_owner;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req  = '1;
      ack  = 1'b1;
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gnt: got %b expected 0000", gnt);
      end
      checks++;
      if (gnt_vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_vld: got %b expected 0", gnt_vld);
      end
      checks++;
      if (gnt_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_id: got %0d expected 0", gnt_id);
      end
   endtask

   task automatic test_priority();
      int e;
      do_reset();
      req = 4'b1111;
      ack = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         e = k % N;
         checks++;
         if ({gnt_vld, gnt_id} !== {1'b1, e[1:0]}) begin
            errors++;
            $display("FAIL priority_rr[%0d]: got vld=%b id=%0d expected vld=1 id=%0d",
                     k, gnt_vld, gnt_id, e);
         end
      end
   endtask

   task automatic test_weighting();
      int exp_id[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      int e;
      do_reset();
      wgt = {4'd1, 4'd1, 4'd1, 4'd3};
      req = 4'b0011;
      ack = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         e = exp_id[k];
         checks++;
         if ({gnt_vld, gnt_id} !== {1'b1, e[1:0]}) begin
            errors++;
            $display("FAIL weighting[%0d]: got vld=%b id=%0d expected vld=1 id=%0d",
                     k, gnt_vld, gnt_id, e);
         end
      end
   endtask

   task automatic test_early_last();
      do_reset();
      wgt = {4'd1, 4'd5, 4'd1, 4'd1};
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL early_last_grant: got %b expected 0100", gnt);
      end
      ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         last = (k == 2);
         tick();
         checks++;
         if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL early_last_beat[%0d]: got %b expected 0100", k, gnt);
         end
      end
      // Re-grant must carry a fresh credit of 5: four beats stay, fifth hands over.
      last = 1'b0;
      req  = 4'b0101;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (gnt !== ((k == 4) ? 4'b0001 : 4'b0100)) begin
            errors++;
            $display("FAIL early_last_regrant[%0d]: got %b expected %b",
                     k, gnt, (k == 4) ? 4'b0001 : 4'b0100);
         end
      end
   endtask

   task automatic test_abort();
      do_reset();
      req = 4'b0010;
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL abort_owner: got %b expected 0010", gnt);
      end
      req = 4'b1000;
      tick();
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL abort_handover: got %b expected 1000", gnt);
      end
      req = 4'b0011;
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL abort_lowest: got %b expected 0001", gnt);
      end
   endtask

   task automatic test_weight0_stall();
      do_reset();
      wgt = {4'd1, 4'd1, 4'd1, 4'd0};
      req = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL stall[%0d]: got %b expected 0001", k, gnt);
         end
      end
      req = 4'b0011;
      ack = 1'b1;
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL weight0_one_beat: got %b expected 0010", gnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wgt = {4'd4, 4'd1, 4'd1, 4'd1};
      req = 4'b1000;
      tick();
      ack = 1'b1;
      tick();
      tick();
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL reset_mid_owner: got %b expected 1000", gnt);
      end
      ack = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({gnt_vld, gnt_id, gnt} !== 7'b0_00_0000) begin
         errors++;
         $display("FAIL reset_mid_drop: got vld=%b id=%0d gnt=%b expected 0/0/0000",
                  gnt_vld, gnt_id, gnt);
      end
      req = 4'b1001;
      @(negedge clk);
      rstn = 1'b1;
      tick();
      checks++;
      if ({gnt_id, gnt} !== 6'b00_0001) begin
         errors++;
         $display("FAIL reset_mid_regrant: got id=%0d gnt=%b expected 0/0001", gnt_id, gnt);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] eg;
      logic         ev;
      logic [IW-1:0] ei;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            wgt[i*WW +: WW] = WW'($urandom_range(0, 5));
         end
         ack  = 1'($urandom_range(0, 1));
         last = ($urandom_range(0, 7) == 0);
         model_step();
         tick();
         eg = '0;
         if (m_owner >= 0) eg[m_owner] = 1'b1;
         ev = (m_owner >= 0);
         ei = IW'(m_id);
         checks++;
         if ({gnt_vld, gnt_id, gnt} !== {ev, ei, eg}) begin
            errors++;
            $display("FAIL random[%0d]: got vld=%b id=%0d gnt=%b expected vld=%b id=%0d gnt=%b",
                     c, gnt_vld, gnt_id, gnt, ev, ei, eg);
         end
      end
   endtask

   initial begin
      rstn = 1'b0;
      req  = '0;
      wgt  = '0;
      ack  = 1'b0;
      last = 1'b0;
      test_reset();
      test_priority();
      test_weighting();
      test_early_last();
      test_abort();
      test_weight0_stall();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
